id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised instruction-decode stage for the pipelined processor. It contains a register file with write-through bypass, a configurable immediate extender, load-use hazard detection with stall generation, and flush support. All decoded values are captured in an ID/EX pipeline register, so every output is registered. It sits between the IF/ID register and the EX stage and feeds the forwarding unit through rs_fw and rt_fw.

Parameters:
DATA_W, 16, datapath and register width
REG_ADDR_W, 3, register address width; register file has 2**REG_ADDR_W entries
IMM_W, 6, immediate field width before extension (IMM_W < DATA_W)
FUNCT_W, 3, funct field width
SIGN_EXT, 1, 1 = sign-extend the immediate, 0 = zero-extend it

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  IF/ID holds a valid instruction
rs  in  REG_ADDR_W  source register 1
rt  in  REG_ADDR_W  source register 2 / load destination
rd  in  REG_ADDR_W  R-type destination
funct  in  FUNCT_W  function field
imm  in  IMM_W  immediate field
PC4ID  in  DATA_W  PC+4 of the instruction
WB  in  DATA_W  write-back data
WriteRegister  in  REG_ADDR_W  write-back destination
regWrite  in  1  write-back enable
ex_mem_read  in  1  instruction currently in EX is a load
flush  in  1  squash the instruction in ID (branch/jump taken)
stall_out  out  1  combinational; hold PC and IF/ID this cycle
out_valid  out  1  ID/EX holds a valid instruction
dado1  out  DATA_W  rs operand
dado2  out  DATA_W  rt operand
sinalextendido  out  DATA_W  extended immediate
rt_mux, rd_mux  out  REG_ADDR_W  destination candidates for the EX mux
rs_fw, rt_fw  out  REG_ADDR_W  source ids for the forwarding unit
funct_out  out  FUNCT_W  registered funct
PC4ID_out  out  DATA_W  registered PC+4

Behaviour:
- Reset: on a rising edge with reset=1, all registered outputs and all register-file entries go to 0. Reset beats every other input, including a simultaneous regWrite.
- Register file:
  - A write happens on the rising edge when regWrite=1 and WriteRegister!=0.
  - Register 0 always reads 0; writes to it are ignored.
  - Reads are combinational.
  - Bypass: if regWrite=1, WriteRegister!=0 and WriteRegister equals the read address, the read returns WB in the same cycle.
- Extension:
  - SIGN_EXT=1: replicate imm[IMM_W-1] into bits DATA_W-1..IMM_W.
  - SIGN_EXT=0: fill those bits with 0.
- Hazard detection:
  - hazard = ex_mem_read & out_valid & in_valid & (rt_mux!=0) & (rt_mux==rs | rt_mux==rt).
  - stall_out = hazard & ~flush.
- ID/EX register update, evaluated each rising edge in this priority order:
  1. reset: load all zeros.
  2. flush=1, or stall_out=1, or in_valid=0: load a bubble (out_valid=0, all data and id outputs 0).
  3. Otherwise: load the decoded values with out_valid=1.
- Latency: 1 cycle from the IF/ID fields to the outputs.
- During a stall the upstream logic holds IF/ID, so the same instruction is re-decoded next cycle. In that cycle out_valid=0, so the hazard clears and a one-cycle stall is guaranteed.
- The register-file write still occurs during a stall or flush; only the ID/EX capture is bubbled.
- There is no internal operation that can be left mid-way. A reset asserted while stalled clears state on the next edge, and stall_out drops once out_valid=0.

Test Plan:
All scenarios use the default parameters.
- Reset: hold reset for 2 cycles with regWrite=1, WriteRegister=3, WB=16'h1234 -> all outputs 0 and R3 still reads 0 after reset drops.
- Write then read with bypass: regWrite=1, WriteRegister=2, WB=16'hBEEF while rs=2, in_valid=1 -> next cycle dado1=16'hBEEF, out_valid=1. Writing R0 with 16'hFFFF then reading rs=0 -> dado1=0.
- Extension: imm=6'b100001 -> sinalextendido=16'hFFE1. Rebuild with SIGN_EXT=0 -> 16'h0021.
- Load-use: cycle n captures a load with rt=4; at cycle n+1 hold ex_mem_read=1 and present rs=4 -> stall_out=1, next cycle out_valid=0; the re-presented instruction is then captured with out_valid=1 and stall_out=0.
- Flush beats stall: same hazard condition plus flush=1 -> stall_out=0 and out_valid=0 next cycle.
- Passthrough: PC4ID=16'h0042, funct=3'b101, rd=6 -> after 1 cycle PC4ID_out=16'h0042, funct_out=3'b101, rd_mux=6, rs_fw and rt_fw equal the inputs.

Source files
------------

// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
//
// Instruction-decode stage: register file with write-through bypass,
// immediate extender, load-use hazard detection and flush handling. Every
// decoded value is captured in the ID/EX register, so all data outputs are
// registered one cycle after the IF/ID fields are presented.
//
// Ports
//   clock, reset      rising-edge clock, synchronous active-high reset
//   in_valid          IF/ID holds a valid instruction
//   rs, rt, rd        register ids from IF/ID
//   funct, imm, PC4ID remaining IF/ID fields
//   WB, WriteRegister, regWrite   write-back port into the register file
//   ex_mem_read       instruction in EX is a load
//   flush             squash the instruction in ID
//   stall_out         combinational stall request for PC and IF/ID
//   out_valid         ID/EX holds a valid instruction
//   dado1, dado2      rs / rt operands
//   sinalextendido    extended immediate
//   rt_mux, rd_mux    destination candidates for the EX mux
//   rs_fw, rt_fw      source ids for the forwarding unit
//   funct_out, PC4ID_out   registered funct and PC+4
// -----------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int IMM_W      = 6,
    parameter int FUNCT_W    = 3,
    parameter int SIGN_EXT   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [FUNCT_W-1:0]    funct,
    input  logic [IMM_W-1:0]      imm,
    input  logic [DATA_W-1:0]     PC4ID,
    input  logic [DATA_W-1:0]     WB,
    input  logic [REG_ADDR_W-1:0] WriteRegister,
    input  logic                  regWrite,
    input  logic                  ex_mem_read,
    input  logic                  flush,
    output logic                  stall_out,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     dado1,
    output logic [DATA_W-1:0]     dado2,
    output logic [DATA_W-1:0]     sinalextendido,
    output logic [REG_ADDR_W-1:0] rt_mux,
    output logic [REG_ADDR_W-1:0] rd_mux,
    output logic [REG_ADDR_W-1:0] rs_fw,
    output logic [REG_ADDR_W-1:0] rt_fw,
    output logic [FUNCT_W-1:0]    funct_out,
    output logic [DATA_W-1:0]     PC4ID_out
);

    localparam int NREGS = 1 << REG_ADDR_W;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];

    logic wr_en;
    assign wr_en = regWrite && (WriteRegister != '0);

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (wr_en) begin
            rf_d[WriteRegister] = WB;
        end
        // Entry 0 is hard-wired to zero regardless of what is written.
        rf_d[0] = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Combinational read ports. The bypass lets an instruction in ID see
    // the value being written back on this very edge.
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    always_comb begin
        rd1 = '0;
        if (rs != '0) begin
            if (wr_en && (WriteRegister == rs)) rd1 = WB;
            else                                rd1 = rf_q[rs];
        end
    end

    always_comb begin
        rd2 = '0;
        if (rt != '0) begin
            if (wr_en && (WriteRegister == rt)) rd2 = WB;
            else                                rd2 = rf_q[rt];
        end
    end

    // ------------------------------------------------------------------
    // Immediate extension
    // ------------------------------------------------------------------
    logic              ext_fill;
    logic [DATA_W-1:0] imm_ext;

    assign ext_fill = (SIGN_EXT != 0) ? imm[IMM_W-1] : 1'b0;
    assign imm_ext  = {{(DATA_W-IMM_W){ext_fill}}, imm};

    // ------------------------------------------------------------------
    // ID/EX register state
    // ------------------------------------------------------------------
    logic                  out_valid_q,      out_valid_d;
    logic [DATA_W-1:0]     dado1_q,          dado1_d;
    logic [DATA_W-1:0]     dado2_q,          dado2_d;
    logic [DATA_W-1:0]     sinalextendido_q, sinalextendido_d;
    logic [REG_ADDR_W-1:0] rt_mux_q,         rt_mux_d;
    logic [REG_ADDR_W-1:0] rd_mux_q,         rd_mux_d;
    logic [REG_ADDR_W-1:0] rs_fw_q,          rs_fw_d;
    logic [REG_ADDR_W-1:0] rt_fw_q,          rt_fw_d;
    logic [FUNCT_W-1:0]    funct_q,          funct_d;
    logic [DATA_W-1:0]     pc4_q,            pc4_d;

    // ------------------------------------------------------------------
    // Load-use hazard: the load sitting in ID/EX (and now in EX) targets a
    // register the current ID instruction reads. Register 0 never hazards.
    // Because a stall bubbles ID/EX, out_valid drops on the next cycle and
    // the stall can never last more than one cycle.
    // ------------------------------------------------------------------
    logic hazard;

    assign hazard = ex_mem_read && out_valid_q && in_valid &&
                    (rt_mux_q != '0) &&
                    ((rt_mux_q == rs) || (rt_mux_q == rt));

    // Flush wins: the squashed instruction must not hold up the front end.
    assign stall_out = hazard && !flush;

    logic bubble;
    assign bubble = flush || stall_out || !in_valid;

    always_comb begin
        out_valid_d      = 1'b0;
        dado1_d          = '0;
        dado2_d          = '0;
        sinalextendido_d = '0;
        rt_mux_d         = '0;
        rd_mux_d         = '0;
        rs_fw_d          = '0;
        rt_fw_d          = '0;
        funct_d          = '0;
        pc4_d            = '0;
        if (!bubble) begin
            out_valid_d      = 1'b1;
            dado1_d          = rd1;
            dado2_d          = rd2;
            sinalextendido_d = imm_ext;
            rt_mux_d         = rt;
            rd_mux_d         = rd;
            rs_fw_d          = rs;
            rt_fw_d          = rt;
            funct_d          = funct;
            pc4_d            = PC4ID;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q      <= 1'b0;
            dado1_q          <= '0;
            dado2_q          <= '0;
            sinalextendido_q <= '0;
            rt_mux_q         <= '0;
            rd_mux_q         <= '0;
            rs_fw_q          <= '0;
            rt_fw_q          <= '0;
            funct_q          <= '0;
            pc4_q            <= '0;
        end else begin
            out_valid_q      <= out_valid_d;
            dado1_q          <= dado1_d;
            dado2_q          <= dado2_d;
            sinalextendido_q <= sinalextendido_d;
            rt_mux_q         <= rt_mux_d;
            rd_mux_q         <= rd_mux_d;
            rs_fw_q          <= rs_fw_d;
            rt_fw_q          <= rt_fw_d;
            funct_q          <= funct_d;
            pc4_q            <= pc4_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign dado1          = dado1_q;
    assign dado2          = dado2_q;
    assign sinalextendido = sinalextendido_q;
    assign rt_mux         = rt_mux_q;
    assign rd_mux         = rd_mux_q;
    assign rs_fw          = rs_fw_q;
    assign rt_fw          = rt_fw_q;
    assign funct_out      = funct_q;
    assign PC4ID_out      = pc4_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe
//
// Directed bench for id_stage_pipe. A second instance built with
// SIGN_EXT=0 shares all inputs so both extension modes are checked from the
// same stimulus. Inputs change 1 time unit after the rising edge and outputs
// are sampled at that same point (registered ones) or just before the next
// edge (combinational stall_out).
// -----------------------------------------------------------------------------
module tb_id_stage_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [2:0]  rs, rt, rd;
    logic [2:0]  funct;
    logic [5:0]  imm;
    logic [15:0] PC4ID;
    logic [15:0] WB;
    logic [2:0]  WriteRegister;
    logic        regWrite;
    logic        ex_mem_read;
    logic        flush;

    logic        stall_out, out_valid;
    logic [15:0] dado1, dado2, sinalextendido, PC4ID_out;
    logic [2:0]  rt_mux, rd_mux, rs_fw, rt_fw, funct_out;

    logic        z_stall_out, z_out_valid;
    logic [15:0] z_dado1, z_dado2, z_sinalextendido, z_PC4ID_out;
    logic [2:0]  z_rt_mux, z_rd_mux, z_rs_fw, z_rt_fw, z_funct_out;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    id_stage_pipe dut (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .PC4ID(PC4ID),
        .WB(WB), .WriteRegister(WriteRegister), .regWrite(regWrite),
        .ex_mem_read(ex_mem_read), .flush(flush),
        .stall_out(stall_out), .out_valid(out_valid),
        .dado1(dado1), .dado2(dado2), .sinalextendido(sinalextendido),
        .rt_mux(rt_mux), .rd_mux(rd_mux), .rs_fw(rs_fw), .rt_fw(rt_fw),
        .funct_out(funct_out), .PC4ID_out(PC4ID_out)
    );

    id_stage_pipe #(.SIGN_EXT(0)) dut_z (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .PC4ID(PC4ID),
        .WB(WB), .WriteRegister(WriteRegister), .regWrite(regWrite),
        .ex_mem_read(ex_mem_read), .flush(flush),
        .stall_out(z_stall_out), .out_valid(z_out_valid),
        .dado1(z_dado1), .dado2(z_dado2), .sinalextendido(z_sinalextendido),
        .rt_mux(z_rt_mux), .rd_mux(z_rd_mux), .rs_fw(z_rs_fw), .rt_fw(z_rt_fw),
        .funct_out(z_funct_out), .PC4ID_out(z_PC4ID_out)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; rs = 0; rt = 0; rd = 0; funct = 0;
        imm = 0; PC4ID = 0; ex_mem_read = 1'b0; flush = 1'b0;
        regWrite = 1'b1; WriteRegister = 3'd3; WB = 16'h1234;

        // Reset beats a simultaneous write to R3.
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_dado1", {16'd0, dado1}, 32'd0);
        chk("rst_sext",  {16'd0, sinalextendido}, 32'd0);
        chk("rst_pc4",   {16'd0, PC4ID_out}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);

        reset = 1'b0; regWrite = 1'b0; in_valid = 1'b1; rs = 3'd3;
        tick();
        chk("r3_after_rst", {16'd0, dado1}, 32'd0);
        chk("valid_after_rst", {31'd0, out_valid}, 32'd1);

        // Write R2 with rs=2 in the same cycle: bypass path.
        regWrite = 1'b1; WriteRegister = 3'd2; WB = 16'hBEEF; rs = 3'd2;
        tick();
        chk("bypass_dado1", {16'd0, dado1}, 32'h0000BEEF);
        chk("bypass_valid", {31'd0, out_valid}, 32'd1);

        // Stored value read back without bypass.
        regWrite = 1'b0; WB = 16'h0000;
        tick();
        chk("stored_dado1", {16'd0, dado1}, 32'h0000BEEF);

        // Writes to R0 are ignored, including the bypass.
        regWrite = 1'b1; WriteRegister = 3'd0; WB = 16'hFFFF; rs = 3'd0;
        tick();
        chk("r0_bypass", {16'd0, dado1}, 32'd0);
        regWrite = 1'b0;
        tick();
        chk("r0_stored", {16'd0, dado1}, 32'd0);

        // Immediate extension, negative and positive, both builds.
        imm = 6'b100001;
        tick();
        chk("sext_neg", {16'd0, sinalextendido}, 32'h0000FFE1);
        chk("zext_neg", {16'd0, z_sinalextendido}, 32'h00000021);
        imm = 6'b011111;
        tick();
        chk("sext_pos", {16'd0, sinalextendido}, 32'h0000001F);
        chk("zext_pos", {16'd0, z_sinalextendido}, 32'h0000001F);

        // Passthrough, with rt bypassed from a same-cycle write to R5.
        imm = 0; PC4ID = 16'h0042; funct = 3'b101; rd = 3'd6; rs = 3'd1; rt = 3'd5;
        regWrite = 1'b1; WriteRegister = 3'd5; WB = 16'h5555;
        tick();
        regWrite = 1'b0;
        chk("pt_pc4",   {16'd0, PC4ID_out}, 32'h00000042);
        chk("pt_funct", {29'd0, funct_out}, 32'd5);
        chk("pt_rd",    {29'd0, rd_mux}, 32'd6);
        chk("pt_rsfw",  {29'd0, rs_fw}, 32'd1);
        chk("pt_rtfw",  {29'd0, rt_fw}, 32'd5);
        chk("pt_rtmux", {29'd0, rt_mux}, 32'd5);
        chk("pt_dado2", {16'd0, dado2}, 32'h00005555);

        // in_valid=0 loads a bubble.
        in_valid = 1'b0;
        tick();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_pc4",   {16'd0, PC4ID_out}, 32'd0);

        // Load-use: capture a load with rt=4, then rs=4 with EX being a load.
        in_valid = 1'b1; rs = 3'd1; rt = 3'd4; rd = 3'd0; PC4ID = 16'h0010;
        tick();
        chk("ld_rtmux", {29'd0, rt_mux}, 32'd4);
        ex_mem_read = 1'b1; rs = 3'd4; rt = 3'd2; PC4ID = 16'h0014;
        #3;
        chk("lu_stall", {31'd0, stall_out}, 32'd1);
        tick();
        chk("lu_bubble", {31'd0, out_valid}, 32'd0);
        ex_mem_read = 1'b0;
        #3;
        chk("lu_stall_clear", {31'd0, stall_out}, 32'd0);
        tick();
        chk("lu_replay_valid", {31'd0, out_valid}, 32'd1);
        chk("lu_replay_rsfw",  {29'd0, rs_fw}, 32'd4);
        chk("lu_replay_pc4",   {16'd0, PC4ID_out}, 32'h00000014);
        chk("lu_replay_stall", {31'd0, stall_out}, 32'd0);

        // Hazard via rt match as well.
        rs = 3'd1; rt = 3'd3;
        tick();
        ex_mem_read = 1'b1; rs = 3'd0; rt = 3'd3;
        #3;
        chk("lu_rt_stall", {31'd0, stall_out}, 32'd1);

        // Flush beats the same hazard.
        flush = 1'b1;
        #1;
        chk("flush_nostall", {31'd0, stall_out}, 32'd0);
        tick();
        chk("flush_bubble", {31'd0, out_valid}, 32'd0);
        chk("flush_dado2",  {16'd0, dado2}, 32'd0);
        flush = 1'b0; ex_mem_read = 1'b0;

        // Load whose destination is R0 never stalls.
        rs = 3'd0; rt = 3'd0;
        tick();
        ex_mem_read = 1'b1;
        #3;
        chk("r0_nohazard", {31'd0, stall_out}, 32'd0);
        ex_mem_read = 1'b0;

        // Reset clears captured state mid-stream.
        rs = 3'd2; rt = 3'd0;
        tick();
        chk("pre_rst_dado1", {16'd0, dado1}, 32'h0000BEEF);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;
        tick();
        chk("mid_rst_r2", {16'd0, dado1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
